// File: rtl/des_arb_pkg.sv
// Shared types and widths for the Triple-DES job arbiter.
package des_arb_pkg;

    localparam int DES_BLOCK_W  = 64;
    localparam int KEY_BUNDLE_W = 192;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: with both requesters asking, the one not served
// last wins. After reset requester 1 counts as last served, so requester 0 wins.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_grant;

    // One-hot grant, favouring the requester that was not served last
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Remember the winner only when the grant is actually taken
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (advance && (grant != 2'b00)) begin
            last_grant <= grant[1];
        end
    end

endmodule

// File: rtl/des_job_arbiter.sv
// Shares one Triple-DES engine between two requesters. A job is granted,
// issued with a one-cycle start pulse, watched for completion or timeout, and
// its result is held until the owning requester consumes it.
module des_job_arbiter
    import des_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 16
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic                    req0_encr,
    input  logic [DES_BLOCK_W-1:0]  req0_data,
    input  logic [KEY_BUNDLE_W-1:0] req0_keys,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic                    req1_encr,
    input  logic [DES_BLOCK_W-1:0]  req1_data,
    input  logic [KEY_BUNDLE_W-1:0] req1_keys,
    output logic                    rsp0_valid,
    input  logic                    rsp0_ready,
    output logic [DES_BLOCK_W-1:0]  rsp0_data,
    output logic                    rsp0_err,
    output logic                    rsp1_valid,
    input  logic                    rsp1_ready,
    output logic [DES_BLOCK_W-1:0]  rsp1_data,
    output logic                    rsp1_err,
    output logic                    des_enable,
    output logic                    des_encr,
    output logic [DES_BLOCK_W-1:0]  des_data,
    output logic [DES_BLOCK_W-1:0]  des_key1,
    output logic [DES_BLOCK_W-1:0]  des_key2,
    output logic [DES_BLOCK_W-1:0]  des_key3,
    input  logic [DES_BLOCK_W-1:0]  des_output,
    input  logic                    des_done,
    output logic                    busy,
    output logic                    grant_id,
    output logic [CNT_W-1:0]        jobs_done
);

    localparam int              TO_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    arb_state_t              state;
    arb_state_t              state_next;
    logic [1:0]              arb_req;
    logic [1:0]              arb_grant;
    logic                    arb_advance;
    logic                    op_encr;
    logic [DES_BLOCK_W-1:0]  op_data;
    logic [KEY_BUNDLE_W-1:0] op_keys;
    logic [TO_W-1:0]         to_cnt;
    logic                    timeout_hit;
    logic                    rsp_hs;
    logic [DES_BLOCK_W-1:0]  result;
    logic                    result_err;

    assign arb_req     = {req1_valid, req0_valid};
    assign timeout_hit = (to_cnt == TO_LAST);
    assign rsp_hs      = (state == RESP) && (grant_id ? rsp1_ready : rsp0_ready);

    rr_arbiter2 u_rr (
        .clk     (HCLK),
        .rst     (HRESET),
        .req     (arb_req),
        .advance (arb_advance),
        .grant   (arb_grant)
    );

    // Engine operands come straight from the job registers so they stay put for the whole job
    assign des_encr = op_encr;
    assign des_data = op_data;
    assign des_key1 = op_keys[191:128];
    assign des_key2 = op_keys[127:64];
    assign des_key3 = op_keys[63:0];

    // Result is only visible on the owning requester's response port
    assign rsp0_data = rsp0_valid ? result : '0;
    assign rsp1_data = rsp1_valid ? result : '0;
    assign rsp0_err  = rsp0_valid & result_err;
    assign rsp1_err  = rsp1_valid & result_err;

    // State register
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: done beats timeout in BUSY, and a handshake always returns to IDLE first
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (arb_grant != 2'b00) state_next = ISSUE;
            ISSUE:   state_next = BUSY;
            BUSY:    if (des_done || timeout_hit) state_next = RESP;
            RESP:    if (rsp_hs) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Per-state outputs; readies are held low while reset is asserted even if a valid is up
    always_comb begin
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        des_enable  = 1'b0;
        rsp0_valid  = 1'b0;
        rsp1_valid  = 1'b0;
        arb_advance = 1'b0;
        busy        = (state != IDLE);
        case (state)
            IDLE: begin
                arb_advance = !HRESET;
                req0_ready  = arb_grant[0] && !HRESET;
                req1_ready  = arb_grant[1] && !HRESET;
            end
            ISSUE: des_enable = 1'b1;
            RESP: begin
                rsp0_valid = !grant_id;
                rsp1_valid = grant_id;
            end
            default: ;
        endcase
    end

    // Capture the granted job's operands, and the engine result or a timeout error
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            grant_id   <= 1'b0;
            op_encr    <= 1'b0;
            op_data    <= '0;
            op_keys    <= '0;
            result     <= '0;
            result_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_grant != 2'b00) begin
                        grant_id <= arb_grant[1];
                        op_encr  <= arb_grant[1] ? req1_encr : req0_encr;
                        op_data  <= arb_grant[1] ? req1_data : req0_data;
                        op_keys  <= arb_grant[1] ? req1_keys : req0_keys;
                    end
                end
                BUSY: begin
                    if (des_done) begin
                        result     <= des_output;
                        result_err <= 1'b0;
                    end else if (timeout_hit) begin
                        result     <= '0;
                        result_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Timeout counter: cleared at issue, counts BUSY cycles that see no completion
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            to_cnt <= '0;
        end else if (state == ISSUE) begin
            to_cnt <= '0;
        end else if ((state == BUSY) && !des_done && !timeout_hit) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    // Count successfully delivered results; wraps naturally at all-ones
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            jobs_done <= '0;
        end else if (rsp_hs && !result_err) begin
            jobs_done <= jobs_done + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_des_job_arbiter.sv
// Directed bench for des_job_arbiter with a behavioural engine whose latency is
// set per job. Short timeout and narrow counter keep boundary cases quick.
module tb_des_job_arbiter;

    localparam int TB_TIMEOUT = 12;
    localparam int TB_CNT_W   = 4;
    localparam logic [63:0] FIXED_OUT = 64'hDEADBEEF00000000;

    logic          HCLK;
    logic          HRESET;
    logic          req0_valid, req0_ready, req0_encr;
    logic [63:0]   req0_data;
    logic [191:0]  req0_keys;
    logic          req1_valid, req1_ready, req1_encr;
    logic [63:0]   req1_data;
    logic [191:0]  req1_keys;
    logic          rsp0_valid, rsp0_ready, rsp0_err;
    logic [63:0]   rsp0_data;
    logic          rsp1_valid, rsp1_ready, rsp1_err;
    logic [63:0]   rsp1_data;
    logic          des_enable, des_encr;
    logic [63:0]   des_data, des_key1, des_key2, des_key3;
    logic [63:0]   des_output = 64'h0;
    logic          des_done   = 1'b0;
    logic          busy, grant_id;
    logic [TB_CNT_W-1:0] jobs_done;

    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    logic [TB_CNT_W-1:0] exp_jobs = '0;

    int            model_delay     = 0;
    int            model_left      = 0;
    bit            model_run       = 1'b0;
    bit            model_use_fixed = 1'b0;
    int            enable_pulses   = 0;

    typedef struct {
        bit           v0, v1;
        bit           e0, e1;
        logic [63:0]  d0, d1;
        logic [191:0] k0, k1;
        int           delay;
        bit           fixed;
        bit           exp_id;
        bit           exp_err;
    } vec_t;

    localparam int NVEC = 7;
    vec_t vecs [NVEC];

    des_job_arbiter #(
        .TIMEOUT_CYCLES (TB_TIMEOUT),
        .CNT_W          (TB_CNT_W)
    ) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_encr  (req0_encr),
        .req0_data  (req0_data),
        .req0_keys  (req0_keys),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_encr  (req1_encr),
        .req1_data  (req1_data),
        .req1_keys  (req1_keys),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp0_data  (rsp0_data),
        .rsp0_err   (rsp0_err),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp1_data  (rsp1_data),
        .rsp1_err   (rsp1_err),
        .des_enable (des_enable),
        .des_encr   (des_encr),
        .des_data   (des_data),
        .des_key1   (des_key1),
        .des_key2   (des_key2),
        .des_key3   (des_key3),
        .des_output (des_output),
        .des_done   (des_done),
        .busy       (busy),
        .grant_id   (grant_id),
        .jobs_done  (jobs_done)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Free-running cycle count, used for latency measurement
    always @(posedge HCLK) cyc <= cyc + 1;

    // Stand-in for the engine result: depends on mode, data and all three keys in order
    function automatic logic [63:0] engineModel(input logic encr, input logic [63:0] data,
                                                input logic [63:0] k1, input logic [63:0] k2,
                                                input logic [63:0] k3);
        return data ^ k1 ^ (k2 << 1) ^ (k3 >> 1) ^ {64{encr}};
    endfunction

    // Engine model: answers model_delay cycles after the start pulse (0 = never answers)
    always @(negedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            model_run  = 1'b0;
            model_left = 0;
            des_done   = 1'b0;
        end else begin
            des_done = 1'b0;
            if (model_run) begin
                model_left = model_left - 1;
                if (model_left == 0) begin
                    des_done   = 1'b1;
                    model_run  = 1'b0;
                    des_output = model_use_fixed ? FIXED_OUT :
                                 engineModel(des_encr, des_data, des_key1, des_key2, des_key3);
                end
            end
            if (des_enable) begin
                enable_pulses = enable_pulses + 1;
                if (model_delay > 0) begin
                    model_run  = 1'b1;
                    model_left = model_delay;
                end
            end
        end
    end

    // Global bound so a stuck design can never hang the run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            failures = failures + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Runs one job whose request inputs were driven at the current falling edge
    task automatic runJob(input bit exp_id, input logic [63:0] exp_data, input bit exp_err,
                          input int delay, input int hold, input bit keep_valid, input bit poke_other);
        int          start;
        int          pulses0;
        int          exp_lat;
        bit          got;
        bit          stable;
        logic [63:0] snap;
        model_delay = delay;
        exp_lat     = exp_err ? (TB_TIMEOUT + 1) : (delay + 1);
        #1;
        pulses0 = enable_pulses;
        checkOutput("req0_ready_at_grant", req0_ready, !exp_id);
        checkOutput("req1_ready_at_grant", req1_ready, exp_id);
        @(negedge HCLK);
        if (!keep_valid) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
        checkOutput("des_enable_at_issue", des_enable, 1'b1);
        checkOutput("grant_id", grant_id, exp_id);
        checkOutput("req_ready_at_issue", {req1_ready, req0_ready}, 2'b00);
        start = cyc;
        got   = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge HCLK);
            if (rsp0_valid || rsp1_valid) got = 1'b1;
        end
        if (!got) begin
            checks   = checks + 1;
            failures = failures + 1;
            $display("[TB] FAIL rsp_wait: no response within 60 cycles, expected one");
            return;
        end
        checkOutput("rsp_latency", cyc - start, exp_lat);
        checkOutput("rsp_valid_pair", {rsp1_valid, rsp0_valid}, exp_id ? 2'b10 : 2'b01);
        checkOutput("rsp_data", exp_id ? rsp1_data : rsp0_data, exp_data);
        checkOutput("rsp_err", exp_id ? rsp1_err : rsp0_err, exp_err);
        checkOutput("des_enable_pulses", enable_pulses - pulses0, 1);
        stable = 1'b1;
        snap   = exp_id ? rsp1_data : rsp0_data;
        if (poke_other) begin
            if (exp_id) req0_valid = 1'b1;
            else        req1_valid = 1'b1;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge HCLK);
            if ((exp_id ? rsp1_data : rsp0_data) !== snap || (exp_id ? rsp1_valid : rsp0_valid) !== 1'b1 ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0)
                stable = 1'b0;
        end
        if (hold > 0) checkOutput("rsp_hold_stable", stable, 1'b1);
        if (poke_other) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
        if (exp_id) rsp1_ready = 1'b1;
        else        rsp0_ready = 1'b1;
        #1;
        checkOutput("no_grant_in_handshake", {req1_ready, req0_ready}, 2'b00);
        @(negedge HCLK);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        if (!exp_err) exp_jobs = exp_jobs + 1'b1;
        checkOutput("jobs_done", jobs_done, exp_jobs);
        checkOutput("idle_after_handshake", busy, 1'b0);
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [63:0] exp_data;
        @(negedge HCLK);
        req0_valid = v.v0;  req0_encr = v.e0;  req0_data = v.d0;  req0_keys = v.k0;
        req1_valid = v.v1;  req1_encr = v.e1;  req1_data = v.d1;  req1_keys = v.k1;
        model_use_fixed = v.fixed;
        if (v.exp_err)     exp_data = 64'h0;
        else if (v.fixed)  exp_data = FIXED_OUT;
        else if (v.exp_id) exp_data = engineModel(v.e1, v.d1, v.k1[191:128], v.k1[127:64], v.k1[63:0]);
        else               exp_data = engineModel(v.e0, v.d0, v.k0[191:128], v.k0[127:64], v.k0[63:0]);
        runJob(v.exp_id, exp_data, v.exp_err, v.delay, 0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [191:0] ka, kb;
        bit           seen;
        ka = {64'h133457799BBCDFF1, 64'h0E329232EA6D0D73, 64'h1122334455667788};
        kb = {64'hA5A5A5A5A5A5A5A5, 64'h5A5A5A5A0F0F0F0F, 64'hF0F0F0F012345678};
        //            v0    v1    e0    e1    d0                     d1                     k0  k1  dly fix id    err
        vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 64'h0123456789ABCDEF, 64'h0,                 ka, kb, 10, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 64'h0,                 64'hFEDCBA9876543210, ka, kb, 1,  1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 64'h1111111111111111, 64'h2222222222222222, ka, kb, 5,  1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 64'h3333333333333333, 64'h4444444444444444, kb, ka, 12, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 64'h5555555555555555, 64'h0,                 ka, kb, 0,  1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 64'h6666666666666666, 64'h7777777777777777, ka, kb, 13, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 64'h0,                 64'h8888888888888888, kb, kb, 3,  1'b0, 1'b1, 1'b0};

        HRESET     = 1'b1;
        req0_valid = 1'b0;  req0_encr = 1'b0;  req0_data = '0;  req0_keys = '0;
        req1_valid = 1'b0;  req1_encr = 1'b0;  req1_data = '0;  req1_keys = '0;
        rsp0_ready = 1'b0;  rsp1_ready = 1'b0;
        repeat (2) @(negedge HCLK);
        checkOutput("reset_ctrl", {busy, grant_id, des_enable, des_encr, rsp0_valid, rsp1_valid, req0_ready, req1_ready}, 8'h00);
        checkOutput("reset_jobs_done", jobs_done, 0);
        checkOutput("reset_des_data", des_data | des_key1 | des_key2 | des_key3, 64'h0);
        HRESET = 1'b0;

        $display("[TB] table vectors");
        for (int i = 0; i < NVEC; i++) applyStimulus(vecs[i]);

        $display("[TB] both requesters continuously valid for four jobs");
        @(negedge HCLK);
        req0_valid = 1'b1;  req0_encr = 1'b1;  req0_data = 64'hA0A0A0A0A0A0A0A0;  req0_keys = ka;
        req1_valid = 1'b1;  req1_encr = 1'b0;  req1_data = 64'h0B0B0B0B0B0B0B0B;  req1_keys = kb;
        model_use_fixed = 1'b0;
        runJob(1'b0, engineModel(1'b1, 64'hA0A0A0A0A0A0A0A0, ka[191:128], ka[127:64], ka[63:0]), 1'b0, 2, 0, 1'b1, 1'b0);
        runJob(1'b1, engineModel(1'b0, 64'h0B0B0B0B0B0B0B0B, kb[191:128], kb[127:64], kb[63:0]), 1'b0, 4, 0, 1'b1, 1'b0);
        runJob(1'b0, engineModel(1'b1, 64'hA0A0A0A0A0A0A0A0, ka[191:128], ka[127:64], ka[63:0]), 1'b0, 1, 0, 1'b1, 1'b0);
        runJob(1'b1, engineModel(1'b0, 64'h0B0B0B0B0B0B0B0B, kb[191:128], kb[127:64], kb[63:0]), 1'b0, 3, 0, 1'b0, 1'b0);

        $display("[TB] response held back for 20 cycles while requester 0 waits");
        @(negedge HCLK);
        req1_valid = 1'b1;  req1_encr = 1'b1;  req1_data = 64'hC3C3C3C3C3C3C3C3;  req1_keys = ka;
        runJob(1'b1, engineModel(1'b1, 64'hC3C3C3C3C3C3C3C3, ka[191:128], ka[127:64], ka[63:0]), 1'b0, 6, 20, 1'b0, 1'b1);

        $display("[TB] reset in the middle of a job");
        @(negedge HCLK);
        req0_valid = 1'b1;  req0_data = 64'h0F1E2D3C4B5A6978;  model_delay = 10;
        @(negedge HCLK);
        req0_valid = 1'b0;
        repeat (3) @(negedge HCLK);
        #2;
        HRESET = 1'b1;
        #1;
        checkOutput("midreset_ctrl", {busy, grant_id, des_enable, des_encr, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err}, 8'h00);
        checkOutput("midreset_des_bus", des_data | des_key1 | des_key2 | des_key3, 64'h0);
        checkOutput("midreset_rsp_data", rsp0_data | rsp1_data, 64'h0);
        checkOutput("midreset_jobs_done", jobs_done, 0);
        @(negedge HCLK);
        HRESET   = 1'b0;
        exp_jobs = '0;
        seen     = 1'b0;
        repeat (15) begin
            @(negedge HCLK);
            if (rsp0_valid || rsp1_valid || busy) seen = 1'b1;
        end
        checkOutput("no_rsp_after_reset", seen, 1'b0);
        @(negedge HCLK);
        req0_valid = 1'b1;  req0_encr = 1'b0;  req0_data = 64'h1234000000005678;  req0_keys = kb;
        req1_valid = 1'b1;  req1_encr = 1'b1;  req1_data = 64'h9999999999999999;  req1_keys = ka;
        runJob(1'b0, engineModel(1'b0, 64'h1234000000005678, kb[191:128], kb[127:64], kb[63:0]), 1'b0, 2, 0, 1'b0, 1'b0);

        $display("[TB] completed-job counter wrap");
        for (int j = 0; j < 15; j++) begin
            @(negedge HCLK);
            req0_valid = 1'b1;  req0_encr = 1'b1;  req0_data = 64'(j);  req0_keys = ka;
            runJob(1'b0, engineModel(1'b1, 64'(j), ka[191:128], ka[127:64], ka[63:0]), 1'b0, 1, 0, 1'b0, 1'b0);
        end
        checkOutput("jobs_done_wrapped", jobs_done, 0);

        repeat (2) @(negedge HCLK);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
